// File: rtl/cordic_result_fifo.sv
// rtl/cordic_result_fifo.sv - first-word fall-through result buffer behind the CORDIC output stage
module cordic_result_fifo #(
  parameter int OUTPUT_WIDTH = 16,
  parameter int DEPTH        = 16,
  parameter int AF_MARGIN    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [OUTPUT_WIDTH-1:0]    in_x,
  input  logic [OUTPUT_WIDTH-1:0]    in_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUTPUT_WIDTH-1:0]    out_x,
  output logic [OUTPUT_WIDTH-1:0]    out_y,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = 2 * OUTPUT_WIDTH;

  // Each entry holds {x, y}; the wrap bit in the pointers separates full from empty.
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          rd_en;
  logic          wr_en;
  logic [PW-1:0] free;
  logic [DW-1:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A read frees the head slot in the same edge, so a full FIFO can still accept a word.
  assign rd_en = !empty && out_ready;
  assign wr_en = in_valid && (!full || rd_en);

  assign out_valid = !empty;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_x     = empty ? '0 : head[DW-1:OUTPUT_WIDTH];
  assign out_y     = empty ? '0 : head[OUTPUT_WIDTH-1:0];

  // Flag early enough that every result still in the CORDIC pipeline has a slot.
  assign free        = PW'(DEPTH) - count;
  assign almost_full = (32'(free) <= 32'(AF_MARGIN));

  // Storage is not reset; contents behind the pointers are meaningless.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem[wr_ptr[AW-1:0]] <= {in_x, in_y};
    end
  end

  // Pointer, occupancy and sticky overflow tracking; clear overrides any traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (wr_en && !rd_en) begin
        count <= count + PW'(1);
      end else if (rd_en && !wr_en) begin
        count <= count - PW'(1);
      end
      if (in_valid && !wr_en) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cordic_result_fifo.sv
// tb/tb_cordic_result_fifo.sv - directed self-checking bench for cordic_result_fifo
module tb_cordic_result_fifo;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic [4:0]  count;
  logic        almost_full;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [15:0] q[$];

  cordic_result_fifo #(
    .OUTPUT_WIDTH(16),
    .DEPTH(16),
    .AF_MARGIN(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .in_valid(in_valid),
    .in_x(in_x),
    .in_y(in_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x(out_x),
    .out_y(out_y),
    .count(count),
    .almost_full(almost_full),
    .overflow(overflow)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] x, input logic [15:0] y);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_almost_full", 32'(almost_full), 0);
    chk("reset_overflow", 32'(overflow), 0);
    chk("reset_out_x", 32'(out_x), 0);
    chk("reset_out_y", 32'(out_y), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single word: 1.0 / -0.5, held while out_ready is low
    push(16'h0100, 16'hFF80);
    chk("single_out_valid", 32'(out_valid), 1);
    chk("single_out_x", 32'(out_x), 32'h0100);
    chk("single_out_y", 32'(out_y), 32'hFF80);
    chk("single_count", 32'(count), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_out_x", 32'(out_x), 32'h0100);
      chk("hold_out_y", 32'(out_y), 32'hFF80);
      chk("hold_out_valid", 32'(out_valid), 1);
    end
    do_clear();
    chk("clear1_count", 32'(count), 0);

    // almost_full threshold: free=8 asserts, free=9 does not
    for (int i = 0; i < 7; i++) push(16'(i), ~16'(i));
    chk("af_count7", 32'(count), 7);
    chk("af_at7", 32'(almost_full), 0);
    push(16'd7, ~16'd7);
    chk("af_count8", 32'(count), 8);
    chk("af_at8", 32'(almost_full), 1);
    chk("af_head_x", 32'(out_x), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("af_after_read_count", 32'(count), 7);
    chk("af_after_read", 32'(almost_full), 0);
    chk("af_after_read_head_x", 32'(out_x), 1);
    chk("af_after_read_head_y", 32'(out_y), 32'hFFFE);
    do_clear();

    // overflow: 17 writes, 17th dropped
    for (int i = 0; i < 17; i++) push(16'h1000 + 16'(i), 16'h2000 + 16'(i));
    chk("ovf_count", 32'(count), 16);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_almost_full", 32'(almost_full), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain_x", 32'(out_x), 32'(16'h1000 + 16'(i)));
      chk("ovf_drain_y", 32'(out_y), 32'(16'h2000 + 16'(i)));
      tick();
    end
    out_ready = 1'b0;
    chk("ovf_drained_valid", 32'(out_valid), 0);
    chk("ovf_drained_count", 32'(count), 0);
    chk("ovf_drained_x", 32'(out_x), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("empty_read_count", 32'(count), 0);
    do_clear();
    chk("ovf_cleared", 32'(overflow), 0);

    // full with simultaneous read and write across pointer wrap
    for (int i = 0; i < 16; i++) push(16'(i), 16'h8000 | 16'(i));
    chk("fullrw_start_count", 32'(count), 16);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_x     = 16'(16 + k);
      in_y     = 16'h8000 | 16'(16 + k);
      chk("fullrw_head_x", 32'(out_x), 32'(k));
      tick();
      chk("fullrw_count", 32'(count), 16);
      chk("fullrw_overflow", 32'(overflow), 0);
    end
    in_valid = 1'b0;
    for (int k = 20; k < 36; k++) begin
      chk("fullrw_drain_x", 32'(out_x), 32'(k));
      chk("fullrw_drain_y", 32'(out_y), 32'(16'h8000 | 16'(k)));
      tick();
    end
    out_ready = 1'b0;
    chk("fullrw_empty", 32'(out_valid), 0);

    // continuous input, toggling ready, checked against a queue model
    q.delete();
    for (int c = 0; c < 14; c++) begin
      in_valid  = 1'b1;
      in_x      = 16'h3000 + 16'(c);
      in_y      = 16'h4000 + 16'(c);
      out_ready = (c % 2 == 0);
      if (q.size() > 0 && out_ready) begin
        chk("stream_head_x", 32'(out_x), 32'(q[0]));
        void'(q.pop_front());
      end
      if (q.size() < 16) q.push_back(in_x);
      tick();
      chk("stream_count", 32'(count), 32'(q.size()));
    end
    clear = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("stream_clear_count", 32'(count), 0);
    chk("stream_clear_valid", 32'(out_valid), 0);
    chk("stream_clear_overflow", 32'(overflow), 0);

    // asynchronous reset at count=5 with overflow set
    for (int i = 0; i < 17; i++) push(16'h5000 + 16'(i), 16'h6000 + 16'(i));
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    out_ready = 1'b0;
    chk("pre_reset_count", 32'(count), 5);
    chk("pre_reset_overflow", 32'(overflow), 1);
    chk("pre_reset_head_x", 32'(out_x), 32'h500B);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_count", 32'(count), 0);
    chk("async_overflow", 32'(overflow), 0);
    chk("async_almost_full", 32'(almost_full), 0);
    chk("async_out_x", 32'(out_x), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push(16'hABCD, 16'h1234);
    chk("post_reset_valid", 32'(out_valid), 1);
    chk("post_reset_x", 32'(out_x), 32'hABCD);
    chk("post_reset_y", 32'(out_y), 32'h1234);
    chk("post_reset_count", 32'(count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_result_fifo.md
Name: cordic_result_fifo

Overview:
- Downstream buffer that consumes the fixed-point (x, y) results leaving the CORDIC output interface and presents them to a consumer under valid/ready backpressure.
- The CORDIC pipeline cannot stall. The block therefore raises almost_full early enough that upstream issue logic can stop injecting operands while all in-flight results still have slots.
- Overflow is never silent: it sets a sticky flag.

Parameters:
- OUTPUT_WIDTH, 16, width of each result word (signed Q7.8: sign, 7 int, 8 frac).
- DEPTH, 16, number of entries; must be a power of two, >= 2.
- AF_MARGIN, 8, almost_full asserts when free entries <= AF_MARGIN. Default equals pipeline latency ITERATION_NUMBER+2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush: empties the FIFO and clears overflow.
- in_valid  input  1  result word present this cycle; no ready is returned.
- in_x  input  OUTPUT_WIDTH  result x, Q7.8 signed.
- in_y  input  OUTPUT_WIDTH  result y, Q7.8 signed.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head this cycle.
- out_x  output  OUTPUT_WIDTH  head x.
- out_y  output  OUTPUT_WIDTH  head y.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  (DEPTH - count) <= AF_MARGIN.
- overflow  output  1  sticky: a write was dropped.

Behaviour:
- Reset (rst_n=0, asynchronous) forces the following, independent of clk:
  - rd/wr pointers, count, out_valid, almost_full and overflow all 0.
  - Storage contents are don't-care.
  - out_x/out_y read 0 while the FIFO is empty.
- Storage:
  - DEPTH x (2*OUTPUT_WIDTH) flop array.
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - empty when the pointers are equal; full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally at DEPTH with no skipped entries.
- Handshake and outputs:
  - Write event: in_valid=1 and (not full, or a read occurs in the same cycle).
  - Read event: out_valid=1 and out_ready=1.
  - out_valid = not empty.
  - out_x/out_y are driven from the head entry (first-word fall-through), and are 0 when empty.
  - Output data must remain stable while out_valid=1 and out_ready=0.
- Latency: a word written at edge N is visible on out_* with out_valid=1 after edge N. There is no combinational in→out bypass when empty.
- count:
  - +1 on write only, -1 on read only, unchanged on both or neither.
  - almost_full is derived combinationally from the registered count.
- Boundary cases:
  - Full with in_valid=1 and no read: word dropped, overflow<=1, pointers and count unchanged.
  - Full with in_valid=1 and a read: both occur, count stays DEPTH, overflow not set.
  - Empty with out_ready=1: no read, nothing changes.
  - Empty with in_valid=1: write only, out_valid=1 next cycle.
- clear:
  - Has priority over same-cycle read/write. Next state: empty, count 0, overflow 0.
  - A word presented in the clear cycle is discarded and does not set overflow.
- overflow stays 1 until clear or reset; further drops keep it at 1.
- Data is stored bit-exact; no saturation, rounding or sign manipulation.
- Reset mid-stream: contents lost; after release the FIFO behaves as freshly reset and the first write lands in entry 0.

Test Plan:
- Reset, then write x=16'h0100 (1.0), y=16'hFF80 (-0.5) with out_ready=0 → next cycle out_valid=1, out_x=0100, out_y=FF80, count=1; data holds for 5 cycles.
- Write 8 words, out_ready=0 → count=8, almost_full=1 (free=8); after 1 read, almost_full=0 at count=7.
- Write 17 words, out_ready=0 → count=16, overflow=1. Draining yields the first 16 words in order; the 17th is absent.
- At count=16, in_valid=1 and out_ready=1 for 20 cycles with incrementing x → count stays 16, overflow=0, output order preserved across pointer wrap.
- Continuous in_valid with out_ready toggling 1,0,1,0 → data order matches input and count never exceeds 16. clear mid-stream → count=0, out_valid=0, overflow=0 next cycle.
- Assert rst_n=0 asynchronously between edges at count=5 → out_valid, count, overflow and almost_full drop immediately. After release, a single write → out_valid=1 next cycle with that word.
